// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the dsp_mac_seq controller and its tag pipeline.
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam int         PIPE_LAT  = 3;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

  // The first product of a vector restarts P (Z=0); later ones add onto P.
  // Idle slots also drive OPM_FIRST so the pin rests at its reset value.
  function automatic logic [7:0] opmode_for(input logic v, input logic first);
    return (v && !first) ? OPM_ACC : OPM_FIRST;
  endfunction

endpackage

// File: rtl/dsp_mac_tagpipe.sv
// Tag shift register that follows each operand pair through the DSP registers
// (A1/B1, M, P) and exposes the taps that drive the slice's clock enables.
module dsp_mac_tagpipe
  import dsp_mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] tag_in,
  output logic       s1_v,
  output logic       s1_first,
  output logic       s2_v,
  output logic       s3_last_v
);

  tag_t pipe_q [PIPE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_t'(tag_in);
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign s1_v      = pipe_q[0].v;
  assign s1_first  = pipe_q[0].first;
  assign s2_v      = pipe_q[1].v;
  // The last product of the vector now sits in P.
  assign s3_last_v = pipe_q[PIPE_LAT-1].v & pipe_q[PIPE_LAT-1].last;

endmodule

// File: rtl/dsp_mac_seq.sv
// Dot-product controller in front of a dsp_block: streams signed 18x18 pairs
// into the slice and returns one 48-bit accumulated result per vector.
//
// state | meaning
// IDLE  | waiting for the first pair of a vector
// ACCUM | pairs being accepted, last one not yet seen
// FLUSH | last pair accepted, waiting for it to reach P
// HOLD  | result presented on m_data until m_ready
module dsp_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_data,
  output logic [LEN_W-1:0] m_len,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);

  localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q;
  logic             accept;
  logic             capture;
  tag_t             tag0;
  logic             s1_v, s1_first, s2_v, s3_last_v;
  logic [47:0]      m_data_q;
  logic [LEN_W-1:0] m_len_q;
  logic [LEN_W-1:0] len_cnt_q;

  // DSP resets are synchronous, so hold dsp_rst for a few clocks after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q <= RC_W'(RST_CYCLES);
    end else if (rst_cnt_q != '0) begin
      rst_cnt_q <= rst_cnt_q - RC_W'(1);
    end
  end

  assign dsp_rst = (rst_cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    tag0       = '0;
    dsp_a      = '0;
    dsp_b      = '0;
    dsp_cea    = 1'b0;
    dsp_ceb    = 1'b0;

    s_ready    = ((state_q == IDLE) || (state_q == ACCUM)) && !dsp_rst;
    accept     = s_valid && s_ready;
    capture    = (state_q == FLUSH) && s3_last_v;

    tag0.v     = accept;
    tag0.first = accept && (state_q == IDLE);
    tag0.last  = accept && s_last;

    if (accept) begin
      dsp_a   = s_a;
      dsp_b   = s_b;
      dsp_cea = 1'b1;
      dsp_ceb = 1'b1;
    end

    unique case (state_q)
      IDLE:    if (accept) state_d = s_last ? FLUSH : ACCUM;
      ACCUM:   if (accept && s_last) state_d = FLUSH;
      FLUSH:   if (capture) state_d = HOLD;
      HOLD:    if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  dsp_mac_tagpipe u_tagpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_in    (tag0),
    .s1_v      (s1_v),
    .s1_first  (s1_first),
    .s2_v      (s2_v),
    .s3_last_v (s3_last_v)
  );

  // OPMODE is registered inside the slice, so it is driven one stage ahead of P.
  assign dsp_opmode = opmode_for(s1_v, s1_first);
  assign dsp_cem    = s1_v;
  assign dsp_cep    = s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt_q <= '0;
      m_data_q  <= '0;
      m_len_q   <= '0;
    end else begin
      if (accept) begin
        if (state_q == IDLE)        len_cnt_q <= LEN_W'(1);
        else if (len_cnt_q != '1)   len_cnt_q <= len_cnt_q + LEN_W'(1);
      end
      if (capture) begin
        m_data_q <= dsp_p;
        m_len_q  <= len_cnt_q;
      end
    end
  end

  assign m_valid = (state_q == HOLD);
  assign m_data  = m_data_q;
  assign m_len   = m_len_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Self-checking bench for dsp_mac_seq driving a behavioural DSP slice with the
// fixed A1/B1, M, P, OPMODE register configuration.
module tb_dsp_mac_seq;

  localparam int LEN_W      = 4;
  localparam int RST_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [17:0]       s_a = '0;
  logic [17:0]       s_b = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [47:0]       m_data;
  logic [LEN_W-1:0]  m_len;
  logic [17:0]       dsp_a, dsp_b;
  logic [7:0]        dsp_opmode;
  logic              dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst;
  logic [47:0]       dsp_p;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_seq #(.LEN_W(LEN_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_len(m_len),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
    .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  // Behavioural dsp_block: A1/B1 -> M -> P, OPMODE registered, sync reset.
  logic signed [17:0] a1_q, b1_q;
  logic signed [35:0] m_q;
  logic [7:0]         opm_q;
  logic [47:0]        p_q, x_mux, z_mux;

  always_comb begin
    x_mux = (opm_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0;
    z_mux = (opm_q[3:2] == 2'b10) ? p_q : 48'd0;
  end

  always_ff @(posedge clk) begin
    if (dsp_rst) begin
      a1_q <= '0; b1_q <= '0; m_q <= '0; opm_q <= '0; p_q <= '0;
    end else begin
      if (dsp_cea) a1_q <= dsp_a;
      if (dsp_ceb) b1_q <= dsp_b;
      if (dsp_cem) m_q <= 36'(a1_q) * 36'(b1_q);
      opm_q <= dsp_opmode;
      if (dsp_cep) p_q <= x_mux + z_mux;
    end
  end

  assign dsp_p = p_q;

  // Reference model: a vector is a list of pairs; result is sum of a*b.
  logic signed [17:0] vec_a[$];
  logic signed [17:0] vec_b[$];
  int                 vec_gap[$];

  task automatic clear_vec();
    vec_a.delete(); vec_b.delete(); vec_gap.delete();
  endtask

  task automatic load_pair(input logic signed [17:0] a, input logic signed [17:0] b, input int gap);
    vec_a.push_back(a); vec_b.push_back(b); vec_gap.push_back(gap);
  endtask

  function automatic logic [47:0] ref_sum();
    longint acc = 0;
    foreach (vec_a[i]) acc += longint'(vec_a[i]) * longint'(vec_b[i]);
    return acc[47:0];
  endfunction

  function automatic logic [LEN_W-1:0] ref_len();
    int n   = vec_a.size();
    int cap = (1 << LEN_W) - 1;
    return LEN_W'((n > cap) ? cap : n);
  endfunction

  // Drives the queued vector; acc_cyc is the edge number that accepted the final pair.
  task automatic send_vec(input bit mark_last, output int acc_cyc, output bit to);
    to = 1'b0;
    acc_cyc = cyc;
    for (int i = 0; i < vec_a.size(); i++) begin
      s_valid = 1'b0;
      for (int g = 0; g < vec_gap[i]; g++) @(negedge clk);
      s_valid = 1'b1;
      s_a     = vec_a[i];
      s_b     = vec_b[i];
      s_last  = mark_last && (i == vec_a.size() - 1);
      for (int w = 0; w < 64 && !s_ready; w++) @(negedge clk);
      if (!s_ready) to = 1'b1;
      acc_cyc = cyc + 1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid(output int vcyc, output bit to);
    for (int w = 0; w < 100 && !m_valid; w++) @(negedge clk);
    to   = !m_valid;
    vcyc = cyc;
  endtask

  task automatic release_result();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_a = 18'h1234; s_b = 18'h0F0F; s_last = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0h expected 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0h expected 0", m_valid); end
    checks++; if (m_data !== 48'd0) begin errors++; $display("FAIL rst_m_data: got %0h expected 0", m_data); end
    checks++; if (m_len !== '0) begin errors++; $display("FAIL rst_m_len: got %0h expected 0", m_len); end
    checks++; if ({dsp_a, dsp_b} !== 36'd0) begin errors++; $display("FAIL rst_dsp_ab: got %0h expected 0", {dsp_a, dsp_b}); end
    checks++; if ({dsp_cea, dsp_ceb, dsp_cem, dsp_cep} !== 4'b0) begin errors++; $display("FAIL rst_ce: got %0b expected 0000", {dsp_cea, dsp_ceb, dsp_cem, dsp_cep}); end
    checks++; if (dsp_opmode !== 8'h01) begin errors++; $display("FAIL rst_opmode: got %0h expected 01", dsp_opmode); end
    checks++; if (dsp_rst !== 1'b1) begin errors++; $display("FAIL rst_dsp_rst: got %0h expected 1", dsp_rst); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dsp_rst !== 1'b1) begin errors++; $display("FAIL rel1_dsp_rst: got %0h expected 1", dsp_rst); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rel1_s_ready: got %0h expected 0", s_ready); end
    checks++; if (dsp_cea !== 1'b0) begin errors++; $display("FAIL rel1_cea: got %0h expected 0", dsp_cea); end
    @(negedge clk);
    checks++; if (dsp_rst !== 1'b0) begin errors++; $display("FAIL rel2_dsp_rst: got %0h expected 0", dsp_rst); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rel2_s_ready: got %0h expected 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rel2_m_valid: got %0h expected 0", m_valid); end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_single();
    int acc, vc; bit to1, to2;
    clear_vec(); load_pair(18'sd3, 18'sd4, 0);
    send_vec(1'b1, acc, to1);
    checks++; if ({dsp_cem, dsp_cep, dsp_opmode} !== {2'b10, 8'h01}) begin errors++; $display("FAIL single_stage1: got %0h expected %0h", {dsp_cem, dsp_cep, dsp_opmode}, {2'b10, 8'h01}); end
    wait_valid(vc, to2);
    checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL single_timeout: got %0b expected 00", {to1, to2}); end
    checks++; if (vc - acc !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", vc - acc); end
    checks++; if (m_data !== 48'd12) begin errors++; $display("FAIL single_data: got %0h expected c", m_data); end
    checks++; if (m_len !== LEN_W'(1)) begin errors++; $display("FAIL single_len: got %0d expected 1", m_len); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL single_hold_ready: got %0h expected 0", s_ready); end
    release_result();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %0h expected 0", m_valid); end
  endtask

  task automatic test_vector3();
    int acc, vc; bit to1, to2;
    clear_vec(); load_pair(18'sd20, 18'sd50, 0); load_pair(18'sd10, 18'sd30, 0); load_pair(-18'sd5, 18'sd6, 0);
    send_vec(1'b1, acc, to1);
    checks++; if ({dsp_cep, dsp_opmode} !== {1'b1, 8'h09}) begin errors++; $display("FAIL vec3_acc_opmode: got %0h expected %0h", {dsp_cep, dsp_opmode}, {1'b1, 8'h09}); end
    wait_valid(vc, to2);
    checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL vec3_timeout: got %0b expected 00", {to1, to2}); end
    checks++; if (m_data !== 48'd1270) begin errors++; $display("FAIL vec3_data: got %0d expected 1270", m_data); end
    checks++; if (m_len !== LEN_W'(3)) begin errors++; $display("FAIL vec3_len: got %0d expected 3", m_len); end
    release_result();
  endtask

  task automatic test_negative();
    int acc, vc; bit to1, to2;
    clear_vec(); load_pair(-18'sd2, 18'sd3, 0);
    send_vec(1'b1, acc, to1);
    wait_valid(vc, to2);
    checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL neg_timeout: got %0b expected 00", {to1, to2}); end
    checks++; if (m_data !== 48'hFFFF_FFFF_FFFA) begin errors++; $display("FAIL neg_data: got %0h expected fffffffffffa", m_data); end
    release_result();
  endtask

  task automatic test_gaps_backpressure();
    int acc, vc; bit to1, to2;
    clear_vec(); load_pair(18'sd7, 18'sd7, 0); load_pair(18'sd1, 18'sd1, 2);
    send_vec(1'b1, acc, to1);
    wait_valid(vc, to2);
    checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL bp_timeout: got %0b expected 00", {to1, to2}); end
    s_valid = 1'b1; s_a = 18'd2; s_b = 18'd2; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({m_valid, m_data, m_len} !== {1'b1, 48'd50, LEN_W'(2)}) begin errors++; $display("FAIL bp_hold_%0d: got v=%0h d=%0d l=%0d expected v=1 d=50 l=2", i, m_valid, m_data, m_len); end
      checks++; if ({s_ready, dsp_cea} !== 2'b00) begin errors++; $display("FAIL bp_no_accept_%0d: got %0b expected 00", i, {s_ready, dsp_cea}); end
      @(negedge clk);
    end
    release_result();
    checks++; if ({m_valid, s_ready} !== 2'b01) begin errors++; $display("FAIL bp_after_hs: got %0b expected 01", {m_valid, s_ready}); end
    clear_vec(); load_pair(18'sd2, 18'sd2, 0);
    send_vec(1'b1, acc, to1);
    wait_valid(vc, to2);
    checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL bp_next_timeout: got %0b expected 00", {to1, to2}); end
    checks++; if ({m_data, m_len} !== {48'd4, LEN_W'(1)}) begin errors++; $display("FAIL bp_next_data: got d=%0d l=%0d expected d=4 l=1", m_data, m_len); end
    release_result();
  endtask

  task automatic test_reset_mid();
    int acc, vc; bit to1, to2, seen;
    clear_vec(); load_pair(18'sd9, 18'sd9, 0); load_pair(18'sd8, 18'sd8, 0);
    send_vec(1'b0, acc, to1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({dsp_rst, s_ready} !== 2'b10) begin errors++; $display("FAIL mid_rst_seq: got %0b expected 10", {dsp_rst, s_ready}); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_valid: got %0h expected 0", seen); end
    clear_vec(); load_pair(18'sd5, 18'sd5, 0);
    send_vec(1'b1, acc, to1);
    wait_valid(vc, to2);
    checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL mid_timeout: got %0b expected 00", {to1, to2}); end
    checks++; if ({m_data, m_len} !== {48'd25, LEN_W'(1)}) begin errors++; $display("FAIL mid_data: got d=%0d l=%0d expected d=25 l=1", m_data, m_len); end
    release_result();
  endtask

  task automatic test_saturation();
    int acc, vc; bit to1, to2;
    logic [47:0] exp_d;
    clear_vec();
    for (int i = 0; i < 20; i++) load_pair(18'($urandom_range(0, 200)), 18'($urandom_range(0, 200)), 0);
    exp_d = ref_sum();
    send_vec(1'b1, acc, to1);
    wait_valid(vc, to2);
    checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL sat_timeout: got %0b expected 00", {to1, to2}); end
    checks++; if (m_len !== LEN_W'((1 << LEN_W) - 1)) begin errors++; $display("FAIL sat_len: got %0d expected %0d", m_len, (1 << LEN_W) - 1); end
    checks++; if (m_data !== exp_d) begin errors++; $display("FAIL sat_data: got %0h expected %0h", m_data, exp_d); end
    release_result();
  endtask

  task automatic test_random();
    int acc, vc, n; bit to1, to2;
    logic [47:0]      exp_d;
    logic [LEN_W-1:0] exp_l;
    for (int v = 0; v < 25; v++) begin
      clear_vec();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        load_pair(18'($urandom), 18'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      exp_d = ref_sum();
      exp_l = ref_len();
      send_vec(1'b1, acc, to1);
      wait_valid(vc, to2);
      checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL rand%0d_timeout: got %0b expected 00", v, {to1, to2}); end
      checks++; if (m_data !== exp_d) begin errors++; $display("FAIL rand%0d_data: got %0h expected %0h", v, m_data, exp_d); end
      checks++; if (m_len !== exp_l) begin errors++; $display("FAIL rand%0d_len: got %0d expected %0d", v, m_len, exp_l); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_vector3();
    test_negative();
    test_gaps_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
